// File: rtl/fp_add_scheduler.sv
// fp_add_scheduler: round-robin front end that shares one free-running adder among N_REQ requesters,
// steering operands only in safe phases and capturing the result of the job's own pass.
module fp_add_scheduler #(
   parameter int N_REQ   = 4,
   parameter int ID_W    = $clog2(N_REQ),
   parameter int TIMEOUT = 64
) (
   input  logic                  clock_100kHz,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [32*N_REQ-1:0]   req_op_a,
   input  logic [32*N_REQ-1:0]   req_op_b,
   output logic [N_REQ-1:0]      req_ready,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_data,
   output logic [3:0]            resp_status,
   output logic [ID_W-1:0]       resp_id,
   output logic [31:0]           add_op_A,
   output logic [31:0]           add_op_B,
   input  logic [2:0]            add_qual_lugar,
   input  logic [31:0]           add_data_out,
   input  logic [3:0]            add_status_out,
   output logic                  busy
);
   localparam int CW = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {SYNC, ARB, ARMED, BUSY, RESP} state_t;
   state_t r_state, w_next;
   logic [ID_W-1:0] r_last, w_win;
   logic [CW-1:0] r_cnt;
   logic [31:0] w_a [N_REQ];
   logic [31:0] w_b [N_REQ];
   logic [2*N_REQ-1:0] w_dbl;
   logic [N_REQ-1:0] w_rot;
   logic w_safe, w_grant, w_timeout, w_result, w_job;
   for (genvar g = 0; g < N_REQ; g++) begin : g_op
      assign w_a[g] = req_op_a[32*g +: 32];
      assign w_b[g] = req_op_b[32*g +: 32];
   end
   assign w_safe    = add_qual_lugar inside {3'd1, 3'd2, 3'd3, 3'd5};
   assign w_dbl     = {req_valid, req_valid};
   // rotate so bit 0 is the requester right after the last grant
   assign w_rot     = N_REQ'(w_dbl >> (int'(r_last) + 1));
   assign w_grant   = r_state == ARB && w_safe && |req_valid;
   assign req_ready = w_grant ? N_REQ'(1) << w_win : '0;
   assign w_job     = r_state == ARMED || r_state == BUSY;
   assign w_timeout = r_cnt == CW'(TIMEOUT - 1);
   assign w_result  = r_state == BUSY && add_qual_lugar == 3'd4;
   assign busy      = r_state != ARB;
   always_comb begin
      w_win = '0;
      for (int j = N_REQ - 1; j >= 0; j--)
         if (w_rot[j]) w_win = ID_W'((int'(r_last) + 1 + j) % N_REQ);
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         SYNC:    w_next = add_qual_lugar == 3'd1 ? ARB : SYNC;
         ARB:     w_next = w_grant ? ARMED : ARB;
         ARMED:   w_next = w_timeout ? RESP : add_qual_lugar == 3'd0 ? BUSY : ARMED;
         BUSY:    w_next = (w_result || w_timeout) ? RESP : BUSY;
         RESP:    w_next = resp_ready ? ARB : RESP;
         default: w_next = SYNC;
      endcase
   end
   always_ff @(posedge clock_100kHz or negedge reset)
      if (!reset) r_state <= SYNC;
      else r_state <= w_next;
   always_ff @(posedge clock_100kHz or negedge reset)
      if (!reset) begin
         r_last      <= ID_W'(N_REQ - 1);
         r_cnt       <= '0;
         add_op_A    <= '0;
         add_op_B    <= '0;
         resp_id     <= '0;
         resp_valid  <= 1'b0;
         resp_data   <= '0;
         resp_status <= '0;
      end else begin
         if (w_grant) begin
            add_op_A <= w_a[w_win];
            add_op_B <= w_b[w_win];
            resp_id  <= w_win;
            r_last   <= w_win;
         end
         r_cnt <= w_job ? r_cnt + 1'b1 : '0;
         if (w_result) begin
            resp_data   <= add_data_out;
            resp_status <= add_status_out;
            resp_valid  <= 1'b1;
         end else if (w_job && w_timeout) begin
            resp_data   <= '0;
            resp_status <= 4'hF;
            resp_valid  <= 1'b1;
         end else if (r_state == RESP && resp_ready) resp_valid <= 1'b0;
      end
endmodule

// File: tb/tb_fp_add_scheduler.sv
// tb_fp_add_scheduler: scoreboard bench with a phase-accurate stand-in for the shared adder.
module tb_fp_add_scheduler;
   localparam int N = 4;
   typedef struct packed {logic [1:0] id; logic [31:0] data; logic [3:0] st;} rec_t;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n = 1'b0;
   logic [N-1:0] req_valid = '0;
   logic [32*N-1:0] req_op_a = '0, req_op_b = '0;
   logic [N-1:0] req_ready;
   logic resp_valid, busy;
   logic resp_ready = 1'b1;
   logic [31:0] resp_data, add_op_A, add_op_B;
   logic [3:0] resp_status;
   logic [1:0] resp_id;
   logic [2:0] qual;
   logic [31:0] a_data = '0, sa0 = '0, sb0 = '0, sa1 = '0, sb1 = '0;
   logic [3:0] a_st = '0;
   logic a_stable = 1'b1, freeze = 1'b0;
   int p = 0;
   int total = 0, bad = 0, cyc = 0, multi = 0, jobn = 0;
   int jobs_left [N] = '{default: 0};
   logic [2:0] last_q = '0;
   logic [N-1:0] last_rr = '0;
   rec_t exp_q[$], got_q[$];
   int gl[$];

   fp_add_scheduler #(.N_REQ(N), .ID_W(2), .TIMEOUT(64)) dut (
      .clock_100kHz(clk), .reset(rst_n), .req_valid(req_valid), .req_op_a(req_op_a),
      .req_op_b(req_op_b), .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_status(resp_status), .resp_id(resp_id), .add_op_A(add_op_A),
      .add_op_B(add_op_B), .add_qual_lugar(qual), .add_data_out(a_data), .add_status_out(a_st),
      .busy(busy));

   // stand-in arithmetic, not IEEE; the scheduler only passes results through
   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      return a + b + 32'hC200_0000;
   endfunction
   function automatic logic [3:0] fst(input logic [31:0] a, input logic [31:0] b);
      return {2'b00, 2'd3 ^ (a[1:0] ^ b[1:0])};
   endfunction

   // 10-cycle pass: 4,0,0,0,1,2,2,3,5,5; operands sampled in the first two cycles
   always_comb qual = p == 0 ? 3'd4 : p < 4 ? 3'd0 : p == 4 ? 3'd1 : p < 7 ? 3'd2 : p == 7 ? 3'd3 : 3'd5;
   always @(posedge clk) begin
      if (p == 0) begin sa0 <= add_op_A; sb0 <= add_op_B; end
      if (p == 1) begin sa1 <= add_op_A; sb1 <= add_op_B; end
      if (p == 9) begin
         a_data   <= fadd(sa0, sb0);
         a_st     <= fst(sa0, sb0);
         a_stable <= (sa0 == sa1) && (sb0 == sb1);
      end
      if (!(freeze && p == 7)) p <= p == 9 ? 0 : p + 1;
   end

   task automatic load(input int i, input logic [31:0] a, input logic [31:0] b);
      req_op_a[32*i +: 32] = a;
      req_op_b[32*i +: 32] = b;
      req_valid[i] = 1'b1;
   endtask

   task automatic step();
      logic [N-1:0] gr;
      rec_t r;
      @(negedge clk);
      cyc++;
      last_q = qual;
      last_rr = req_ready;
      gr = req_ready & req_valid;
      if ($countones(req_ready) > 1) multi++;
      for (int i = 0; i < N; i++)
         if (gr[i]) begin
            gl.push_back(i);
            r.id = 2'(i);
            r.data = freeze ? 32'h0 : fadd(req_op_a[32*i +: 32], req_op_b[32*i +: 32]);
            r.st = freeze ? 4'hF : fst(req_op_a[32*i +: 32], req_op_b[32*i +: 32]);
            exp_q.push_back(r);
         end
      if (resp_valid && resp_ready) begin
         r.id = resp_id;
         r.data = resp_data;
         r.st = resp_status;
         got_q.push_back(r);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
         if (gr[i]) begin
            if (jobs_left[i] > 0) begin
               jobs_left[i]--;
               jobn++;
               load(i, 32'h3F80_0000 + 32'(jobn * 4096 + i), 32'h4000_0000 + 32'(jobn * 3 + i * 7));
            end else req_valid[i] = 1'b0;
         end
   endtask

   task automatic test_reset();
      step();
      step();
      total++;
      if ({req_ready, resp_valid, resp_data, resp_status, resp_id, add_op_A, add_op_B, busy} !== 108'd1) begin
         bad++;
         $display("FAIL reset_values got rr=%b rv=%b d=%h st=%h id=%0d A=%h B=%h busy=%b want all zero, busy=1",
                  req_ready, resp_valid, resp_data, resp_status, resp_id, add_op_A, add_op_B, busy);
      end
      rst_n = 1'b1;
      for (int n = 0; n < 20 && busy; n++) step();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL sync_exit got busy=%b want 0", busy); end
      total++;
      if ({add_op_A, add_op_B} !== 64'd0) begin
         bad++;
         $display("FAIL sync_ops got A=%h B=%h want 0", add_op_A, add_op_B);
      end
   endtask

   task automatic test_single();
      rec_t g, e;
      gl.delete();
      load(2, 32'h4000_0000, 32'h4000_0000);
      for (int n = 0; n < 60 && got_q.size() == 0; n++) step();
      total++;
      if (gl.size() != 1 || gl[0] != 2) begin bad++; $display("FAIL single_grant got n=%0d want one grant to 2", gl.size()); end
      total++;
      if (a_stable !== 1'b1) begin bad++; $display("FAIL single_ops_stable got %b want 1", a_stable); end
      total++;
      if (got_q.size() != 1) begin bad++; $display("FAIL single_resp_count got %0d want 1", got_q.size()); end
      while (got_q.size() > 0) begin
         g = got_q.pop_front();
         e = '1;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         total++;
         if ({g.id, g.data, g.st} !== {2'd2, 32'h4200_0000, 4'd3}) begin
            bad++;
            $display("FAIL single_value got id=%0d data=%h st=%h want id=2 data=42000000 st=3", g.id, g.data, g.st);
         end
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL single_resp got id=%0d data=%h st=%h want id=%0d data=%h st=%h", g.id, g.data, g.st, e.id, e.data, e.st);
         end
      end
   endtask

   task automatic test_contention();
      rec_t g, e;
      int order [5] = '{0, 1, 2, 3, 0};
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int n = 0; n < 20 && busy; n++) step();
      gl.delete();
      multi = 0;
      jobs_left[0] = 1;
      for (int i = 0; i < N; i++) load(i, 32'h3000_0000 + 32'(i * 5), 32'h0100_0000 + 32'(i * 9 + 1));
      for (int n = 0; n < 400 && got_q.size() < 5; n++) step();
      total++;
      if (gl.size() != 5) begin bad++; $display("FAIL contention_grants got %0d want 5", gl.size()); end
      for (int k = 0; k < 5 && k < gl.size(); k++) begin
         total++;
         if (gl[k] != order[k]) begin bad++; $display("FAIL contention_order[%0d] got %0d want %0d", k, gl[k], order[k]); end
      end
      total++;
      if (multi != 0) begin bad++; $display("FAIL contention_onehot got %0d multi-grant cycles want 0", multi); end
      total++;
      if (got_q.size() != 5) begin bad++; $display("FAIL contention_resp_count got %0d want 5", got_q.size()); end
      while (got_q.size() > 0) begin
         g = got_q.pop_front();
         e = '1;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL contention_resp got id=%0d data=%h st=%h want id=%0d data=%h st=%h", g.id, g.data, g.st, e.id, e.data, e.st);
         end
      end
   endtask

   task automatic test_backpressure();
      rec_t g, e;
      logic [31:0] snap;
      int drift = 0, n0;
      gl.delete();
      resp_ready = 1'b0;
      load(1, 32'h1234_5678, 32'h0000_1111);
      for (int n = 0; n < 60 && !resp_valid; n++) step();
      load(3, 32'hA5A5_0000, 32'h0F0F_0003);
      snap = resp_data;
      n0 = gl.size();
      for (int n = 0; n < 30; n++) begin
         step();
         if (resp_valid !== 1'b1 || resp_data !== snap) drift++;
      end
      total++;
      if (drift != 0 || snap === 32'bx) begin bad++; $display("FAIL bp_hold got %0d unstable cycles want 0", drift); end
      total++;
      if (gl.size() != n0) begin bad++; $display("FAIL bp_no_grant got %0d grants want %0d", gl.size(), n0); end
      resp_ready = 1'b1;
      for (int n = 0; n < 30 && gl.size() == n0; n++) step();
      total++;
      if (gl.size() != n0 + 1 || gl[gl.size()-1] != 3) begin bad++; $display("FAIL bp_next_grant got n=%0d want grant to 3", gl.size() - n0); end
      for (int n = 0; n < 60 && got_q.size() < 2; n++) step();
      total++;
      if (got_q.size() != 2) begin bad++; $display("FAIL bp_resp_count got %0d want 2", got_q.size()); end
      while (got_q.size() > 0) begin
         g = got_q.pop_front();
         e = '1;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL bp_resp got id=%0d data=%h st=%h want id=%0d data=%h st=%h", g.id, g.data, g.st, e.id, e.data, e.st);
         end
      end
   endtask

   task automatic test_window();
      rec_t g, e;
      int early = 0;
      step();
      for (int n = 0; n < 20 && last_q != 3'd4; n++) step();
      load(0, 32'h3E00_0000, 32'h3E00_0005);
      for (int n = 0; n < 15; n++) begin
         step();
         if (!(last_q inside {3'd0, 3'd4})) break;
         if (last_rr != 0) early++;
      end
      total++;
      if (early != 0) begin bad++; $display("FAIL window_early got %0d grants in phase 4/0 want 0", early); end
      total++;
      if (last_rr !== 4'b0001 || !(last_q inside {3'd1, 3'd2, 3'd3, 3'd5})) begin
         bad++;
         $display("FAIL window_grant got rr=%b q=%0d want rr=0001 in safe phase", last_rr, last_q);
      end
      for (int n = 0; n < 60 && got_q.size() == 0; n++) step();
      total++;
      if (got_q.size() != 1) begin bad++; $display("FAIL window_resp_count got %0d want 1", got_q.size()); end
      while (got_q.size() > 0) begin
         g = got_q.pop_front();
         e = '1;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL window_resp got id=%0d data=%h st=%h want id=%0d data=%h st=%h", g.id, g.data, g.st, e.id, e.data, e.st);
         end
      end
   endtask

   task automatic test_timeout();
      rec_t g, e;
      int g_cyc;
      freeze = 1'b1;
      step();
      for (int n = 0; n < 20 && last_q != 3'd3; n++) step();
      gl.delete();
      load(1, 32'h3F00_0000, 32'h3F00_0001);
      for (int n = 0; n < 5 && gl.size() == 0; n++) step();
      g_cyc = cyc;
      for (int n = 0; n < 120 && got_q.size() == 0; n++) step();
      total++;
      if (gl.size() != 1 || got_q.size() != 1 || cyc - g_cyc != 65) begin
         bad++;
         $display("FAIL timeout_latency got grants=%0d resps=%0d cycles=%0d want 1 1 65", gl.size(), got_q.size(), cyc - g_cyc);
      end
      while (got_q.size() > 0) begin
         g = got_q.pop_front();
         e = '1;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         total++;
         if ({g.id, g.data, g.st} !== {2'd1, 32'h0, 4'hF} || g !== e) begin
            bad++;
            $display("FAIL timeout_resp got id=%0d data=%h st=%h want id=1 data=0 st=f", g.id, g.data, g.st);
         end
      end
      freeze = 1'b0;
   endtask

   task automatic test_reset_mid_job();
      rec_t g, e;
      gl.delete();
      load(2, 32'h4040_0000, 32'h4080_0000);
      for (int n = 0; n < 20 && gl.size() == 0; n++) step();
      for (int n = 0; n < 20 && last_q != 3'd0; n++) step();
      for (int n = 0; n < 20 && last_q != 3'd1; n++) step();
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({req_ready, resp_valid, resp_data, resp_status, resp_id, add_op_A, add_op_B, busy} !== 108'd1) begin
         bad++;
         $display("FAIL midjob_reset got rr=%b rv=%b d=%h st=%h id=%0d A=%h B=%h busy=%b want all zero, busy=1",
                  req_ready, resp_valid, resp_data, resp_status, resp_id, add_op_A, add_op_B, busy);
      end
      exp_q.delete();
      step();
      step();
      rst_n = 1'b1;
      for (int n = 0; n < 40; n++) step();
      total++;
      if (got_q.size() != 0) begin bad++; $display("FAIL midjob_stale got %0d responses want 0", got_q.size()); end
      got_q.delete();
      gl.delete();
      load(0, 32'h4100_0000, 32'h4100_0002);
      for (int n = 0; n < 60 && got_q.size() == 0; n++) step();
      total++;
      if (gl.size() != 1 || gl[0] != 0 || got_q.size() != 1) begin
         bad++;
         $display("FAIL midjob_resume got grants=%0d resps=%0d want one grant to 0 and one response", gl.size(), got_q.size());
      end
      while (got_q.size() > 0) begin
         g = got_q.pop_front();
         e = '1;
         if (exp_q.size() > 0) e = exp_q.pop_front();
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL midjob_resp got id=%0d data=%h st=%h want id=%0d data=%h st=%h", g.id, g.data, g.st, e.id, e.data, e.st);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_window();
      test_timeout();
      test_reset_mid_job();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end
endmodule
